// File: rtl/data_memory_responder_pkg.sv
// Shared definitions for the data-memory responder: access kinds, FSM states, frame masks.
package data_memory_responder_pkg;

  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StWait    = 2'd1,
    StRespond = 2'd2
  } state_e;

  // frame_mask[3-k] selects byte k, so the MSB is byte 0.
  localparam logic [3:0] MaskNone   = 4'b0000;
  localparam logic [3:0] MaskByte0  = 4'b1000;
  localparam logic [3:0] MaskByte1  = 4'b0100;
  localparam logic [3:0] MaskByte2  = 4'b0010;
  localparam logic [3:0] MaskByte3  = 4'b0001;
  localparam logic [3:0] MaskHalfLo = 4'b1100;
  localparam logic [3:0] MaskHalfHi = 4'b0011;
  localparam logic [3:0] MaskWord   = 4'b1111;

  function automatic logic [2:0] popcount4(input logic [3:0] m);
    return 3'(m[0]) + 3'(m[1]) + 3'(m[2]) + 3'(m[3]);
  endfunction

  function automatic logic mask_is_half(input logic [3:0] m);
    return (m == MaskHalfLo) || (m == MaskHalfHi);
  endfunction

  function automatic logic mask_is_legal(input logic [3:0] m);
    logic legal;
    case (m)
      MaskNone, MaskByte0, MaskByte1, MaskByte2, MaskByte3,
      MaskHalfLo, MaskHalfHi, MaskWord: legal = 1'b1;
      default:                          legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/data_memory_responder_if.sv
// Data-memory handshake between the LSU (master) and the memory responder (slave).
interface data_memory_responder_if;

  logic        enable;
  logic        memory_state;
  logic [3:0]  frame_mask;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        memory_done;
  logic        error;

  modport master (
    output enable, memory_state, frame_mask, address, write_data,
    input  read_data, memory_done, error
  );

  modport slave (
    input  enable, memory_state, frame_mask, address, write_data,
    output read_data, memory_done, error
  );

endinterface

// File: rtl/data_memory_responder_byte_lane_aligner.sv
// Combinational byte-lane steering: maps a frame mask and byte address onto word lanes
// for stores, and right-justifies and zero-fills load data.
module byte_lane_aligner
  import data_memory_responder_pkg::*;
(
  input  logic [3:0]  frame_mask_i,
  input  logic [1:0]  byte_addr_i,
  input  logic [31:0] write_data_i,
  input  logic [31:0] word_i,
  output logic [31:0] write_data_o,
  output logic [3:0]  lane_en_o,
  output logic [31:0] read_data_o
);

  logic [1:0]  offset;
  logic [2:0]  size;
  logic [3:0]  size_lanes;
  logic [31:0] word_shifted;

  always_comb begin
    case (frame_mask_i)
      MaskWord:               offset = 2'd0;
      MaskHalfLo, MaskHalfHi: offset = {byte_addr_i[1], 1'b0};
      default:                offset = byte_addr_i;
    endcase

    // The mask sets the access width; the lanes touched are that many bytes from offset.
    size         = popcount4(frame_mask_i);
    size_lanes   = 4'((5'd1 << size) - 5'd1);
    lane_en_o    = size_lanes << offset;
    write_data_o = write_data_i << {offset, 3'b000};
    word_shifted = word_i >> {offset, 3'b000};

    read_data_o = '0;
    for (int k = 0; k < 4; k++) begin
      read_data_o[8*k +: 8] = size_lanes[k] ? word_shifted[8*k +: 8] : 8'h00;
    end
  end

endmodule

// File: rtl/data_memory_responder.sv
// Memory-side responder for the LSU data handshake: byte-lane SRAM with wait states.
// Define MEMORY_ERROR_EN to flag misaligned, illegal-mask and out-of-range accesses.
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic                    CLK,
  input logic                    reset,
  data_memory_responder_if.slave bus
);

  localparam logic [3:0] WaitInit = 4'(WAIT_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  count_q, count_d;
  logic        rw_q, rw_d;
  logic [3:0]  mask_q, mask_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] read_data_q, read_data_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic [ADDR_WIDTH-1:0] word_idx;
  logic [31:0]           rd_word, wdata_al, rdata_al;
  logic [3:0]            lane_en;
  logic                  accept, commit, access_err, mem_we;
  logic                  unused_addr_hi;

  assign word_idx       = addr_q[ADDR_WIDTH+1:2];
  assign rd_word        = mem_q[word_idx];
  assign unused_addr_hi = ^addr_q[31:ADDR_WIDTH+2];

  byte_lane_aligner u_aligner (
    .frame_mask_i (mask_q),
    .byte_addr_i  (addr_q[1:0]),
    .write_data_i (wdata_q),
    .word_i       (rd_word),
    .write_data_o (wdata_al),
    .lane_en_o    (lane_en),
    .read_data_o  (rdata_al)
  );

`ifdef MEMORY_ERROR_EN
  always_comb begin
    access_err = !mask_is_legal(mask_q)
               || ((mask_q == MaskWord) && (addr_q[1:0] != 2'b00))
               || (mask_is_half(mask_q) && addr_q[0])
               || ((addr_q >> (ADDR_WIDTH + 2)) != 32'd0);
  end
`else
  assign access_err = 1'b0;
`endif

  assign commit = (state_q == StWait) && (count_q == 4'd0);
  assign mem_we = commit && (rw_q == WRITE) && !access_err;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rw_d        = rw_q;
    mask_d      = mask_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    read_data_d = read_data_q;
    done_d      = 1'b0;
    error_d     = 1'b0;
    accept      = 1'b0;

    unique case (state_q)
      StIdle: accept = bus.enable;
      StWait: begin
        if (count_q != 4'd0) begin
          count_d = count_q - 4'd1;
        end else begin
          state_d = StRespond;
          done_d  = 1'b1;
          error_d = access_err;
          if (access_err) begin
            read_data_d = '0;
          end else if ((rw_q == READ) && (mask_q != MaskNone)) begin
            read_data_d = rdata_al;
          end
        end
      end
      // Sampling enable here as well sustains one request per WAIT_CYCLES+2 cycles.
      StRespond: begin
        state_d = StIdle;
        accept  = bus.enable;
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      state_d = StWait;
      count_d = WaitInit;
      rw_d    = bus.memory_state;
      mask_d  = bus.frame_mask;
      addr_d  = bus.address;
      wdata_d = bus.write_data;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      count_q     <= 4'd0;
      rw_q        <= READ;
      mask_q      <= MaskNone;
      addr_q      <= '0;
      wdata_q     <= '0;
      read_data_q <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rw_q        <= rw_d;
      mask_q      <= mask_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      read_data_q <= read_data_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  // Array contents survive reset; only the request in flight is dropped.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      for (int k = 0; k < 4; k++) begin
        if (lane_en[k]) begin
          mem_q[word_idx][8*k +: 8] <= wdata_al[8*k +: 8];
        end
      end
    end
  end

  assign bus.read_data   = read_data_q;
  assign bus.memory_done = done_q;
  assign bus.error       = error_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Self-checking bench for data_memory_responder: vector table plus scoreboard of
// expected completions, with burst and mid-request reset sequences.
module tb_data_memory_responder;
  import data_memory_responder_pkg::*;

`ifdef MEMORY_ERROR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic CLK   = 1'b0;
  logic reset = 1'b0;

  data_memory_responder_if bus();

  data_memory_responder #(
    .DEPTH_WORDS (1024),
    .ADDR_WIDTH  (10),
    .WAIT_CYCLES (2)
  ) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          cyc;
  } exp_t;

  typedef struct {
    logic        rw;
    logic [3:0]  mask;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic        err;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[22];
  int   total     = 0;
  int   bad       = 0;
  int   cyc       = 0;
  logic prev_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per completion pulse.
  always @(posedge CLK) begin
    exp_t e;
    #1;
    cyc++;
    if (bus.memory_done === 1'b1) begin
      check("done_width", 32'(prev_done), 32'd0);
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done at cycle %0d want none", cyc);
      end else begin
        e = sb_q.pop_front();
        check("read_data", bus.read_data, e.rd);
        check("error", 32'(bus.error), 32'(e.err));
        check("done_cycle", cyc, e.cyc);
      end
    end
    prev_done = bus.memory_done;
  end

  task automatic drive(input logic rw, input logic [3:0] m, input logic [31:0] a,
                       input logic [31:0] wd);
    bus.enable       = 1'b1;
    bus.memory_state = rw;
    bus.frame_mask   = m;
    bus.address      = a;
    bus.write_data   = wd;
  endtask

  task automatic issue(input vec_t v);
    @(negedge CLK);
    drive(v.rw, v.mask, v.addr, v.wdata);
    sb_q.push_back('{rd: v.rd, err: v.err, cyc: cyc + 4});
    @(negedge CLK);
    bus.enable = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] word10;
    int          base;

    vecs[0]  = '{WRITE, 4'b1111, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{READ,  4'b1111, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{WRITE, 4'b1000, 32'h11,   32'h000000AA, 32'hDEADBEEF, 1'b0};
    vecs[3]  = '{READ,  4'b1111, 32'h10,   32'h0,        32'hDEADAAEF, 1'b0};
    vecs[4]  = '{READ,  4'b1000, 32'h11,   32'h0,        32'h000000AA, 1'b0};
    vecs[5]  = '{WRITE, 4'b1100, 32'h12,   32'h00001234, 32'h000000AA, 1'b0};
    vecs[6]  = '{READ,  4'b1100, 32'h12,   32'h0,        32'h00001234, 1'b0};
    vecs[7]  = '{READ,  4'b1111, 32'h10,   32'h0,        32'h1234AAEF, 1'b0};
    vecs[8]  = '{READ,  4'b1000, 32'h13,   32'h0,        32'h00000012, 1'b0};
    vecs[9]  = '{READ,  4'b1100, 32'h10,   32'h0,        32'h0000AAEF, 1'b0};
    // Wraps to word 0x10 unless range checking is built in.
    vecs[10] = '{READ,  4'b1111, 32'h1010, 32'h0, ErrEn ? 32'h0 : 32'h1234AAEF, ErrEn};
    vecs[11] = '{READ,  4'b0000, 32'h14,   32'h0, ErrEn ? 32'h0 : 32'h1234AAEF, 1'b0};
    vecs[12] = '{WRITE, 4'b0000, 32'h10,   32'hFFFFFFFF, ErrEn ? 32'h0 : 32'h1234AAEF, 1'b0};
    vecs[13] = '{READ,  4'b1111, 32'h10,   32'h0,        32'h1234AAEF, 1'b0};
    vecs[14] = '{WRITE, 4'b1111, 32'h14,   32'h01020304, 32'h1234AAEF, 1'b0};
    vecs[15] = '{WRITE, 4'b0100, 32'h17,   32'h0000005A, 32'h1234AAEF, 1'b0};
    vecs[16] = '{READ,  4'b1111, 32'h14,   32'h0,        32'h5A020304, 1'b0};
    vecs[17] = '{READ,  4'b0001, 32'h16,   32'h0,        32'h00000002, 1'b0};
    vecs[18] = '{READ,  4'b1100, 32'h15,   32'h0, ErrEn ? 32'h0 : 32'h00000304, ErrEn};
    vecs[19] = '{WRITE, 4'b1111, 32'h13,   32'hCAFEF00D, ErrEn ? 32'h0 : 32'h00000304, ErrEn};
    vecs[20] = '{READ,  4'b1111, 32'h10,   32'h0, ErrEn ? 32'h1234AAEF : 32'hCAFEF00D, 1'b0};
    vecs[21] = '{READ,  4'b1111, 32'h16,   32'h0, ErrEn ? 32'h0 : 32'h5A020304, ErrEn};
    word10 = ErrEn ? 32'h1234AAEF : 32'hCAFEF00D;

    bus.enable       = 1'b0;
    bus.memory_state = READ;
    bus.frame_mask   = 4'b0000;
    bus.address      = '0;
    bus.write_data   = '0;

    repeat (3) @(negedge CLK);
    check("reset_read_data", bus.read_data, 32'h0);
    check("reset_done", 32'(bus.memory_done), 32'd0);
    check("reset_error", 32'(bus.error), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge CLK);

    for (int i = 0; i < 22; i++) begin
      issue(vecs[i]);
      drain();
    end

    // Enable held high: three reads accepted back to back, completions 4 cycles apart.
    @(negedge CLK);
    drive(READ, 4'b1111, 32'h10, 32'h0);
    base = cyc;
    for (int k = 0; k < 3; k++) begin
      sb_q.push_back('{rd: word10, err: 1'b0, cyc: base + 4 + 4 * k});
    end
    repeat (9) @(negedge CLK);
    bus.enable = 1'b0;
    drain();

    // Reset pulse during WAIT of a write: no completion, no array change, outputs cleared.
    @(negedge CLK);
    drive(WRITE, 4'b1111, 32'h10, 32'h55555555);
    @(negedge CLK);
    bus.enable = 1'b0;
    @(negedge CLK);
    reset = 1'b0;
    #1;
    check("midreset_read_data", bus.read_data, 32'h0);
    check("midreset_done", 32'(bus.memory_done), 32'd0);
    check("midreset_error", 32'(bus.error), 32'd0);
    @(negedge CLK);
    reset = 1'b1;
    repeat (6) @(negedge CLK);
    issue('{READ, 4'b1111, 32'h10, 32'h0, word10, 1'b0});
    drain();

    repeat (3) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
